// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int DIV_N  = 4;
    localparam int DIV_W2 = 2 * DIV_N;
    localparam int DIV_CW = $clog2(DIV_W2);

    // Quotient reported when the divisor is zero: all ones
    localparam logic [DIV_W2-1:0] DBZ_QUOTIENT = '1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell shared with the multiplier rows
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    // Plain sum/carry equations
    always_comb begin
        s_o = a_i ^ b_i ^ c_i;
        c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
    end

endmodule

// File: rtl/restore_step.sv
// rtl/restore_step.sv - one combinational restoring-division step
module restore_step #(
    parameter int N = 4
) (
    input  logic [N:0]   r_i,
    input  logic         q_msb_i,
    input  logic [N-1:0] d_i,
    output logic [N:0]   r_o,
    output logic         q_bit_o
);

    logic [N:0]   t;
    logic [N:0]   d_inv;
    logic [N:0]   diff;
    logic [N+1:0] carry;
    logic         unused_r_msb;

    // R[N] is always zero entering a step; only its low bits shift up
    assign unused_r_msb = r_i[N];
    assign t            = {r_i[N-1:0], q_msb_i};
    assign d_inv        = ~{1'b0, d_i};
    assign carry[0]     = 1'b1;

    // T - D as T + ~D + 1; a final carry of 1 means no borrow, i.e. diff >= 0
    for (genvar i = 0; i <= N; i++) begin : g_row
        full_adder u_fa (
            .a_i (t[i]),
            .b_i (d_inv[i]),
            .c_i (carry[i]),
            .s_o (diff[i]),
            .c_o (carry[i+1])
        );
    end

    // Keep the difference when it fits, otherwise restore T
    always_comb begin
        q_bit_o = carry[N+1];
        r_o     = carry[N+1] ? diff : t;
    end

endmodule

// File: rtl/seq_divider_8x4.sv
// rtl/seq_divider_8x4.sv - iterative restoring divider, 2N-bit by N-bit
module seq_divider_8x4
    import div_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_by_zero
);

    localparam int W2 = 2 * N;
    localparam int CW = (W2 > 1) ? $clog2(W2) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W2 - 1);

    state_t          state_q, state_d;
    logic [N:0]      r_q, r_d;
    logic [W2-1:0]   q_q, q_d;
    logic [N-1:0]    d_q, d_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]   quot_q, quot_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      r_step;
    logic            q_bit;
    logic [W2-1:0]   q_step;

    restore_step #(.N(N)) u_step (
        .r_i     (r_q),
        .q_msb_i (q_q[W2-1]),
        .d_i     (d_q),
        .r_o     (r_step),
        .q_bit_o (q_bit)
    );

    assign q_step = {q_q[W2-2:0], q_bit};

    // Next-state and datapath update; results only move on entering DONE
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    r_d   = '0;
                    q_d   = dividend;
                    d_d   = divisor;
                    cnt_d = '0;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = {W2{1'b1}};
                        rem_d   = dividend[N-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else if (state_q == S_DONE) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    quot_d  = q_step;
                    rem_d   = r_step[N-1:0];
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
